// File: rtl/baud_tick_generator.sv
// baud_tick_generator: fractional UART baud generator with oversample, mid-bit and bit ticks.
module baud_tick_generator #(
  parameter int DIV_WIDTH    = 16,
  parameter int FRAC_WIDTH   = 4,
  parameter int OVS_LOG2     = 4,
  parameter int DEFAULT_INT  = 26,
  parameter int DEFAULT_FRAC = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  baud_int,
  input  logic [FRAC_WIDTH-1:0] baud_frac,
  input  logic                  baud_load,
  input  logic                  phase_clr,
  output logic                  load_pending,
  output logic                  os_tick,
  output logic                  mid_tick,
  output logic                  bit_tick,
  output logic                  clk_out
);
  localparam int OVS = 1 << OVS_LOG2;
  logic [DIV_WIDTH:0]    div_cnt, limit;
  logic [OVS_LOG2-1:0]   os_cnt;
  logic [FRAC_WIDTH-1:0] frac_acc, active_frac, pend_frac, new_frac;
  logic [FRAC_WIDTH:0]   frac_sum;
  logic [DIV_WIDTH-1:0]  active_int, pend_int, new_int;
  logic                  stretch, wrap, apply, mid_hit, bit_hit;
  always_comb begin
    limit    = {1'b0, active_int} + {{DIV_WIDTH{1'b0}}, stretch};
    wrap     = div_cnt == limit;
    apply    = baud_load | load_pending;
    new_int  = baud_load ? baud_int : pend_int;
    new_frac = baud_load ? baud_frac : pend_frac;
    frac_sum = {1'b0, frac_acc} + {1'b0, active_frac};
    mid_hit  = os_cnt == OVS_LOG2'(OVS / 2 - 1);
    bit_hit  = &os_cnt;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt      <= '0;
      os_cnt       <= '0;
      frac_acc     <= '0;
      stretch      <= 1'b0;
      active_int   <= DIV_WIDTH'(DEFAULT_INT);
      active_frac  <= FRAC_WIDTH'(DEFAULT_FRAC);
      pend_int     <= '0;
      pend_frac    <= '0;
      load_pending <= 1'b0;
      os_tick      <= 1'b0;
      mid_tick     <= 1'b0;
      bit_tick     <= 1'b0;
      clk_out      <= 1'b0;
    end else if (!enable || phase_clr) begin
      div_cnt      <= '0;
      os_cnt       <= '0;
      frac_acc     <= '0;
      stretch      <= 1'b0;
      load_pending <= 1'b0;
      os_tick      <= 1'b0;
      mid_tick     <= 1'b0;
      bit_tick     <= 1'b0;
      clk_out      <= 1'b0;
      if (apply) begin
        active_int  <= new_int;
        active_frac <= new_frac;
      end
    end else if (wrap) begin
      div_cnt  <= '0;
      os_cnt   <= os_cnt + 1'b1;
      os_tick  <= 1'b1;
      mid_tick <= mid_hit;
      bit_tick <= bit_hit;
      clk_out  <= bit_hit ? 1'b0 : (mid_hit ? 1'b1 : clk_out);
      // A new divisor restarts the fractional pattern from zero.
      if (apply) begin
        active_int   <= new_int;
        active_frac  <= new_frac;
        frac_acc     <= '0;
        stretch      <= 1'b0;
        load_pending <= 1'b0;
      end else begin
        frac_acc <= frac_sum[FRAC_WIDTH-1:0];
        stretch  <= frac_sum[FRAC_WIDTH];
      end
    end else begin
      div_cnt  <= div_cnt + 1'b1;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      if (baud_load) begin
        pend_int     <= baud_int;
        pend_frac    <= baud_frac;
        load_pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_baud_tick_generator.sv
// tb_baud_tick_generator: table vectors, directed timing sequences and random run against a period-level model.
module tb_baud_tick_generator;
  localparam int OVS = 16;
  logic clk = 0, reset = 0, enable = 0, baud_load = 0, phase_clr = 0;
  logic [15:0] baud_int = 0;
  logic [3:0] baud_frac = 0;
  logic load_pending, os_tick, mid_tick, bit_tick, clk_out;
  int n_cmp = 0, n_bad = 0;
  int m_rem, m_n, m_kf, n;
  logic [15:0] m_ai, m_pi;
  logic [3:0] m_af, m_pf;
  logic m_pend, m_os, m_mid, m_bit, m_clk;

  baud_tick_generator dut (
    .clk(clk), .reset(reset), .enable(enable), .baud_int(baud_int), .baud_frac(baud_frac),
    .baud_load(baud_load), .phase_clr(phase_clr), .load_pending(load_pending), .os_tick(os_tick),
    .mid_tick(mid_tick), .bit_tick(bit_tick), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Period-level model: counts edges left in the current oversample period and
  // derives stretch cycles from floor(k*frac/16) steps since the last divisor change.
  task automatic model_step();
    int c;
    m_os = 0; m_mid = 0; m_bit = 0;
    if (!reset) begin
      m_ai = 26; m_af = 2; m_pend = 0; m_n = 0; m_kf = 0; m_clk = 0; m_rem = 27;
    end else if (!enable || phase_clr) begin
      if (baud_load) begin m_ai = baud_int; m_af = baud_frac; end
      else if (m_pend) begin m_ai = m_pi; m_af = m_pf; end
      m_pend = 0; m_n = 0; m_kf = 0; m_clk = 0; m_rem = int'(m_ai) + 1;
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_os = 1;
        m_mid = (m_n % OVS) == OVS / 2 - 1;
        m_bit = (m_n % OVS) == OVS - 1;
        m_n++;
        if (m_mid) m_clk = 1;
        if (m_bit) m_clk = 0;
        if (baud_load || m_pend) begin
          m_ai = baud_load ? baud_int : m_pi;
          m_af = baud_load ? baud_frac : m_pf;
          m_pend = 0; m_kf = 0; c = 0;
        end else begin
          m_kf++;
          c = (m_kf * int'(m_af)) / 16 - ((m_kf - 1) * int'(m_af)) / 16;
        end
        m_rem = int'(m_ai) + 1 + c;
      end else if (baud_load) begin
        m_pend = 1; m_pi = baud_int; m_pf = baud_frac;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("outputs", {load_pending, os_tick, mid_tick, bit_tick, clk_out}, {m_pend, m_os, m_mid, m_bit, m_clk});
    baud_load = 0;
    phase_clr = 0;
  endtask

  task automatic run_until(input int sel, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!(sel == 0 ? os_tick : sel == 1 ? mid_tick : bit_tick) && cnt < 20000);
    if (cnt >= 20000) check("timeout", cnt, 0);
  endtask

  task automatic load_idle(input logic [15:0] bi, input logic [3:0] bf);
    enable = 0; baud_load = 1; baud_int = bi; baud_frac = bf;
    tick();
    enable = 1;
  endtask

  typedef struct packed {
    logic rs, en, ld, pc;
    logic [15:0] bi;
    logic [3:0] bf;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[14];

  initial begin
    tbl[0]  = {4'b0100, 16'd0, 4'd0, 5'b00000};
    tbl[1]  = {4'b1010, 16'd0, 4'd0, 5'b00000};
    tbl[2]  = {4'b1100, 16'd0, 4'd0, 5'b01000};
    tbl[3]  = {4'b1110, 16'd2, 4'd0, 5'b01000};
    tbl[4]  = {4'b1100, 16'd0, 4'd0, 5'b00000};
    tbl[5]  = {4'b1100, 16'd0, 4'd0, 5'b00000};
    tbl[6]  = {4'b1100, 16'd0, 4'd0, 5'b01000};
    tbl[7]  = {4'b1110, 16'd0, 4'd0, 5'b10000};
    tbl[8]  = {4'b1100, 16'd0, 4'd0, 5'b10000};
    tbl[9]  = {4'b1100, 16'd0, 4'd0, 5'b01000};
    tbl[10] = {4'b1100, 16'd0, 4'd0, 5'b01000};
    tbl[11] = {4'b1101, 16'd0, 4'd0, 5'b00000};
    tbl[12] = {4'b1100, 16'd0, 4'd0, 5'b01000};
    tbl[13] = {4'b1000, 16'd0, 4'd0, 5'b00000};
    for (int i = 0; i < 14; i++) begin
      {reset, enable, baud_load, phase_clr} = {tbl[i].rs, tbl[i].en, tbl[i].ld, tbl[i].pc};
      baud_int = tbl[i].bi;
      baud_frac = tbl[i].bf;
      tick();
      check($sformatf("vec%0d", i), {load_pending, os_tick, mid_tick, bit_tick, clk_out}, tbl[i].exp);
    end
    // Defaults 26/2: 27-clock periods, 28 after every 8th tick, 434-clock bits.
    reset = 0; tick();
    reset = 1; enable = 1;
    run_until(0, n); check("first_os", n, 27);
    for (int j = 2; j <= 17; j++) begin
      run_until(0, n);
      check($sformatf("os_period%0d", j), n, (j - 1) % 8 == 0 ? 28 : 27);
    end
    run_until(2, n);
    run_until(1, n); check("clk_low", n, 217); check("clk_hi_at_mid", clk_out, 1);
    run_until(2, n); check("clk_high", n, 217); check("clk_lo_at_bit", clk_out, 0);
    // Live reload mid-period.
    load_idle(26, 0);
    run_until(0, n); check("os_26_0", n, 27);
    repeat (10) tick();
    baud_load = 1; baud_int = 53; tick();
    check("pending_set", load_pending, 1);
    run_until(0, n); check("old_period_end", n, 16); check("pending_clr", load_pending, 0);
    run_until(0, n); check("new_period", n, 54);
    // Phase restart.
    load_idle(26, 0);
    repeat (5) run_until(0, n);
    repeat (12) tick();
    phase_clr = 1; tick();
    check("pc_quiet", {os_tick, clk_out}, 0);
    run_until(0, n); check("pc_next_os", n, 27);
    for (int k = 2; k <= 16; k++) begin
      run_until(0, n);
      if (k == 8) check("pc_mid8", mid_tick, 1);
      if (k == 16) check("pc_bit16", bit_tick, 1);
    end
    // Reset mid-run restores defaults.
    load_idle(100, 3);
    repeat (150) tick();
    baud_load = 1; baud_int = 7; reset = 0; tick();
    check("reset_outs", {load_pending, os_tick, mid_tick, bit_tick, clk_out}, 0);
    reset = 1;
    run_until(0, n); check("reset_os", n, 27);
    // Slow rate applied while idle.
    load_idle(867, 0);
    check("idle_load_nopend", load_pending, 0);
    run_until(0, n); check("os_868", n, 868);
    run_until(2, n); check("bit_13888", n + 868, 13888);
    // Divisor zero: bit every 16 clocks.
    load_idle(0, 0);
    run_until(2, n); check("bit_16", n, 16);
    run_until(2, n); check("bit_16b", n, 16);
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 199) != 0;
      enable = $urandom_range(0, 49) != 0;
      baud_load = $urandom_range(0, 19) == 0;
      phase_clr = $urandom_range(0, 59) == 0;
      baud_int = 16'($urandom_range(0, 6));
      baud_frac = 4'($urandom);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/baud_tick_generator.md
Name: baud_tick_generator

Overview:
Parametrised UART baud-rate generator, the successor to the single-divisor baud generator. It produces a fractional-divided oversample tick (os_tick), a per-bit tick (bit_tick), a mid-bit sample tick (mid_tick) and a baud-rate square wave (clk_out). The divisor can be reloaded glitch-free at run time, and the phase can be resynchronised by the RX start-bit detector. It sits between the RS232 TX/RX engines and the system clock.

Parameters:
DIV_WIDTH, 16, width of the integer divisor.
FRAC_WIDTH, 4, width of the fractional divisor and accumulator.
OVS_LOG2, 4, log2 of the oversample ratio; OVERSAMPLE = 2**OVS_LOG2; legal range 1..6.
DEFAULT_INT, 26, integer divisor loaded at reset (115200 x16 at 50 MHz).
DEFAULT_FRAC, 2, fractional divisor loaded at reset.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
enable  in  1  run when 1; hold counters cleared when 0
baud_int  in  DIV_WIDTH  integer divisor; os period = baud_int+1 clocks
baud_frac  in  FRAC_WIDTH  fractional part, in units of 1/2**FRAC_WIDTH clock
baud_load  in  1  one-cycle strobe that captures baud_int/baud_frac
phase_clr  in  1  restart the oversample and bit phase
load_pending  out  1  captured divisor not yet applied
os_tick  out  1  one-clock pulse per oversample period
mid_tick  out  1  one-clock pulse at the bit centre
bit_tick  out  1  one-clock pulse at the bit end
clk_out  out  1  square wave, period of one bit

Behaviour:
- Reset is synchronous, active-low: reset==0 sampled at a clk edge.
- Reset values: all outputs 0; div_cnt=0, os_cnt=0, frac_acc=0, stretch=0; active_int=DEFAULT_INT, active_frac=DEFAULT_FRAC; pending=0.
- Priority per edge: reset > enable==0 > phase_clr > normal run.
- enable==0:
  - div_cnt, os_cnt, frac_acc, stretch and clk_out are forced to 0; all ticks are 0.
  - A baud_load, or an existing pending value, is applied to the active registers immediately; load_pending is 0.
- Normal run:
  - limit = active_int + stretch, computed at DIV_WIDTH+1 bits (no overflow).
  - If div_cnt==limit: div_cnt<=0 and os_tick<=1 (registered, high for 1 clock). This is a "wrap".
  - Otherwise: div_cnt<=div_cnt+1 and os_tick<=0.
- At a wrap:
  - {carry,frac_acc} <= frac_acc + active_frac; stretch<=carry, so the following period is extended by 1 clock.
  - os_cnt <= os_cnt+1, modulo OVERSAMPLE.
  - mid_tick<=1 if the old os_cnt==OVERSAMPLE/2-1.
  - bit_tick<=1 if the old os_cnt==OVERSAMPLE-1.
  - clk_out toggles on mid_tick or bit_tick events: low in the first half-bit, high in the second.
- Period and latency:
  - First os_tick is visible after the (active_int+1)-th enabled edge.
  - Average os period = active_int + 1 + active_frac/2**FRAC_WIDTH clocks.
  - bit_tick period = OVERSAMPLE os periods.
- baud_int==0 is legal: os_tick every clock, plus stretch cycles.
- Divisor reload:
  - baud_load captures the inputs into pend_int/pend_frac and sets pending=1 (load_pending=1 from the next cycle).
  - At the next wrap: active<=pend, frac_acc<=0, stretch<=0, pending<=0. The period in progress completes with the old divisor.
  - baud_load coincident with a wrap: the inputs go straight to active at that wrap; pending stays 0.
  - Back-to-back loads: the last one wins.
- phase_clr (enable==1):
  - Clears div_cnt, os_cnt, frac_acc, stretch and clk_out; no tick in that cycle.
  - Applies a pending or simultaneous load immediately.
  - Next os_tick follows the (active_int+1)-th edge after the phase_clr edge.
- Reset mid-operation: on the next edge, all state returns to reset values; any pending load is discarded.
- Ticks are mutually consistent: mid_tick and bit_tick only ever assert in the same cycle as os_tick.

Test Plan:
1. Reset low then high, defaults 26/2, enable=1 -> os periods 27 clocks, with a 28-clock period after every 8th os_tick; bit_tick period exactly 434 clocks; clk_out period 434 clocks with 217/217 high/low spacing ±1.
2. baud_int=867, baud_frac=0, baud_load while enable=0 -> applied immediately (load_pending stays 0); os period 868; bit_tick every 13888 clocks.
3. Running at 26/0, baud_load 53/0 at div_cnt=10 -> current period ends at 27 clocks; load_pending high until that os_tick; following periods 54 clocks.
4. phase_clr at os_cnt=5, div_cnt=12 -> no tick that cycle; next os_tick 27 clocks later; mid_tick after the 8th os_tick; bit_tick after the 16th; clk_out restarts low.
5. reset low for 1 cycle mid-run after loading 100/3 -> all outputs 0 next edge; divisor back to 26/2; first os_tick 27 clocks after reset deassert.
6. baud_int=0, baud_frac=0 -> os_tick high every clock; bit_tick every 16 clocks; baud_load coincident with a wrap takes effect at that wrap.
